resource_pool_arbiter: RTL and testbench

- Shares a pool of identical execution resources (ALU instances or memory ports) among all single-instruction controllers (SICs) in the core.
- Each SIC holds req high for its whole critical region, then pulses release_lock for one cycle.
- The arbiter grants ownership oldest-issue_id-first and publishes the owner of each resource slot, so the datapath mux can route that SIC's request to that slot.

---
 rtl/resource_pool_arbiter_pkg.sv | 26 ++
 rtl/resource_pool_arbiter_oldest_picker.sv | 32 +++
 rtl/resource_pool_arbiter.sv | 120 ++++++++++++
 tb/tb_resource_pool_arbiter.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/resource_pool_arbiter_pkg.sv
// rtl/resource_pool_arbiter_pkg.sv - shared types and the issue-id age rule for the resource pool arbiter
package resource_pool_arbiter_pkg;

  typedef enum logic {
    OWN_FREE = 1'b0,
    OWN_HELD = 1'b1
  } own_state_e;

  // Bit positions inside one packed per-SIC request word {req, req_issue_id, release_lock}
  localparam int RPL_REL_BIT = 0;
  localparam int RPL_ID_LSB  = 1;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // a is older than b when (a - b) mod 2^width has its MSB set; the low bits of a
  // 32-bit difference equal the modular difference, so ids are passed zero-extended.
  function automatic logic issue_id_older(input logic [31:0] a, input logic [31:0] b,
                                          input int unsigned width);
    logic [31:0] diff;
    diff = a - b;
    return diff[width-1];
  endfunction

endpackage

// File: rtl/resource_pool_arbiter_oldest_picker.sv
// rtl/resource_pool_arbiter_oldest_picker.sv - picks the valid entry with the oldest issue id
module oldest_picker
  import resource_pool_arbiter_pkg::*;
#(
  parameter  int N  = 4,
  parameter  int W  = 4,
  localparam int IW = idx_width(N)
) (
  input  logic [N-1:0]        valid,
  input  logic [N-1:0][W-1:0] ids,
  output logic                win_valid,
  output logic [IW-1:0]       win_idx
);

  logic [W-1:0] best_id;

  // Only a strictly older id displaces the current best, so equal ids keep the lowest index.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    best_id   = '0;
    for (int i = 0; i < N; i++) begin
      if (valid[i] && (!win_valid ||
          issue_id_older(32'(ids[i]), 32'(best_id), W))) begin
        win_valid = 1'b1;
        win_idx   = IW'(i);
        best_id   = ids[i];
      end
    end
  end

endmodule

// File: rtl/resource_pool_arbiter.sv
// rtl/resource_pool_arbiter.sv - oldest-first ownership arbiter over a pool of identical resource slots
module resource_pool_arbiter
  import resource_pool_arbiter_pkg::*;
#(
  parameter  int NUM_REQ  = 4,
  parameter  int NUM_RES  = 1,
  parameter  int ID_WIDTH = 4,
  localparam int IDX_W    = idx_width(NUM_REQ),
  localparam int SLOT_W   = idx_width(NUM_RES)
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [NUM_REQ-1:0][ID_WIDTH+1:0]    rpl_in,
  output logic [NUM_REQ-1:0]                  grant,
  output logic [NUM_RES-1:0]                  slot_busy,
  output logic [NUM_RES-1:0][IDX_W-1:0]       slot_owner,
  output logic                                protocol_err
);

  own_state_e                      held_q [NUM_REQ];
  own_state_e                      held_d [NUM_REQ];
  logic [NUM_RES-1:0]              slot_busy_q, slot_busy_d;
  logic [NUM_RES-1:0][IDX_W-1:0]   slot_owner_q, slot_owner_d;
  logic                            protocol_err_q, protocol_err_d;

  logic [NUM_REQ-1:0]                req_v, rel_v, held_v, cand_v;
  logic [NUM_REQ-1:0][ID_WIDTH-1:0]  id_v;
  logic                              win_valid;
  logic [IDX_W-1:0]                  win_idx;
  logic                              free_found;
  logic [SLOT_W-1:0]                 free_idx;

  always_comb begin
    req_v  = '0;
    rel_v  = '0;
    id_v   = '0;
    held_v = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_v[i]  = rpl_in[i][ID_WIDTH+1];
      id_v[i]   = rpl_in[i][RPL_ID_LSB +: ID_WIDTH];
      rel_v[i]  = rpl_in[i][RPL_REL_BIT];
      held_v[i] = (held_q[i] == OWN_HELD);
    end
    cand_v = req_v & ~held_v & ~rel_v;
  end

  oldest_picker #(
    .N (NUM_REQ),
    .W (ID_WIDTH)
  ) u_picker (
    .valid     (cand_v),
    .ids       (id_v),
    .win_valid (win_valid),
    .win_idx   (win_idx)
  );

  // Free slot is chosen from the registered busy map, so a slot released this edge stays idle one cycle.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int s = 0; s < NUM_RES; s++) begin
      if (!slot_busy_q[s] && !free_found) begin
        free_found = 1'b1;
        free_idx   = SLOT_W'(s);
      end
    end
  end

  always_comb begin
    held_d         = held_q;
    slot_busy_d    = slot_busy_q;
    slot_owner_d   = slot_owner_q;
    protocol_err_d = protocol_err_q;

    for (int i = 0; i < NUM_REQ; i++) begin
      if (rel_v[i]) begin
        if (held_q[i] == OWN_HELD) begin
          held_d[i] = OWN_FREE;
          for (int s = 0; s < NUM_RES; s++) begin
            if (slot_busy_q[s] && (slot_owner_q[s] == IDX_W'(i))) begin
              slot_busy_d[s] = 1'b0;
            end
          end
        end else begin
          protocol_err_d = 1'b1;
        end
      end
    end

    if (free_found && win_valid) begin
      held_d[win_idx]        = OWN_HELD;
      slot_busy_d[free_idx]  = 1'b1;
      slot_owner_d[free_idx] = win_idx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REQ; i++) held_q[i] <= OWN_FREE;
      slot_busy_q    <= '0;
      slot_owner_q   <= '0;
      protocol_err_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) held_q[i] <= held_d[i];
      slot_busy_q    <= slot_busy_d;
      slot_owner_q   <= slot_owner_d;
      protocol_err_q <= protocol_err_d;
    end
  end

  always_comb begin
    grant = '0;
    for (int i = 0; i < NUM_REQ; i++) grant[i] = (held_q[i] == OWN_HELD);
  end

  assign slot_busy    = slot_busy_q;
  assign slot_owner   = slot_owner_q;
  assign protocol_err = protocol_err_q;

endmodule

// File: tb/tb_resource_pool_arbiter.sv
// tb/tb_resource_pool_arbiter.sv - directed self-checking bench for resource_pool_arbiter
module tb_resource_pool_arbiter;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [3:0][5:0]  rpl1 = '0;
  logic [3:0][5:0]  rpl2 = '0;
  logic [3:0]       grant1, grant2;
  logic [0:0]       busy1;
  logic [1:0]       busy2;
  logic [0:0][1:0]  owner1;
  logic [1:0][1:0]  owner2;
  logic             err1, err2;
  int               checks = 0;
  int               errors = 0;

  always #5 clk = ~clk;

  resource_pool_arbiter #(.NUM_REQ(4), .NUM_RES(1), .ID_WIDTH(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .rpl_in(rpl1), .grant(grant1),
    .slot_busy(busy1), .slot_owner(owner1), .protocol_err(err1));

  resource_pool_arbiter #(.NUM_REQ(4), .NUM_RES(2), .ID_WIDTH(4)) dut2 (
    .clk(clk), .rst_n(rst_n), .rpl_in(rpl2), .grant(grant2),
    .slot_busy(busy2), .slot_owner(owner2), .protocol_err(err2));

  function automatic logic [5:0] pk(input logic r, input logic [3:0] id, input logic rl);
    return {r, id, rl};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #3;
    checks++; if (grant1 !== 4'b0000) begin errors++; $display("FAIL reset_grant1 got %b want 0000", grant1); end
    checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL reset_busy1 got %b want 0", busy1); end
    checks++; if (owner1[0] !== 2'd0) begin errors++; $display("FAIL reset_owner1 got %0d want 0", owner1[0]); end
    checks++; if (err1 !== 1'b0) begin errors++; $display("FAIL reset_err1 got %b want 0", err1); end
    checks++; if ({grant2, busy2, err2} !== 7'd0) begin errors++; $display("FAIL reset_dut2 got %b want 0", {grant2, busy2, err2}); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    rpl1[2] = pk(1'b1, 4'd3, 1'b0);
    tick();
    checks++; if (grant1 !== 4'b0100) begin errors++; $display("FAIL single_grant got %b want 0100", grant1); end
    checks++; if (busy1 !== 1'b1 || owner1[0] !== 2'd2) begin errors++; $display("FAIL single_slot got busy %b owner %0d want 1 2", busy1, owner1[0]); end
    rpl1[2] = '0;
    tick();
    checks++; if (grant1 !== 4'b0100) begin errors++; $display("FAIL single_req_drop_keeps got %b want 0100", grant1); end
    rpl1[2] = pk(1'b0, 4'd0, 1'b1);
    tick();
    checks++; if (grant1 !== 4'b0000 || busy1 !== 1'b0) begin errors++; $display("FAIL single_release got grant %b busy %b want 0000 0", grant1, busy1); end
    rpl1[2] = '0;
    tick();
  endtask

  task automatic test_age_order();
    rpl1[0] = pk(1'b1, 4'd5, 1'b0);
    rpl1[3] = pk(1'b1, 4'd2, 1'b0);
    tick();
    checks++; if (grant1 !== 4'b1000 || owner1[0] !== 2'd3) begin errors++; $display("FAIL age_first got %b owner %0d want 1000 3", grant1, owner1[0]); end
    rpl1[3] = '0;
    tick();
    checks++; if (grant1 !== 4'b1000) begin errors++; $display("FAIL age_wait got %b want 1000", grant1); end
    rpl1[3] = pk(1'b0, 4'd0, 1'b1);
    tick();
    checks++; if (grant1 !== 4'b0000 || busy1 !== 1'b0) begin errors++; $display("FAIL age_no_bypass got %b busy %b want 0000 0", grant1, busy1); end
    rpl1[3] = '0;
    tick();
    checks++; if (grant1 !== 4'b0001 || owner1[0] !== 2'd0) begin errors++; $display("FAIL age_second got %b owner %0d want 0001 0", grant1, owner1[0]); end
    rpl1[0] = '0;
    tick();
    rpl1[0] = pk(1'b0, 4'd0, 1'b1);
    tick();
    rpl1[0] = '0;
    tick();
    checks++; if (grant1 !== 4'b0000 || err1 !== 1'b0) begin errors++; $display("FAIL age_idle got %b err %b want 0000 0", grant1, err1); end
  endtask

  task automatic test_wrap_and_tie();
    rpl1[1] = pk(1'b1, 4'h1, 1'b0);
    rpl1[2] = pk(1'b1, 4'hF, 1'b0);
    tick();
    checks++; if (grant1 !== 4'b0100) begin errors++; $display("FAIL wrap_first got %b want 0100", grant1); end
    rpl1[2] = pk(1'b0, 4'd0, 1'b1);
    tick();
    rpl1[2] = '0;
    tick();
    checks++; if (grant1 !== 4'b0010 || owner1[0] !== 2'd1) begin errors++; $display("FAIL wrap_second got %b owner %0d want 0010 1", grant1, owner1[0]); end
    rpl1[1] = pk(1'b0, 4'd0, 1'b1);
    tick();
    rpl1[1] = '0;
    rpl1[0] = pk(1'b1, 4'd7, 1'b0);
    rpl1[1] = pk(1'b1, 4'd7, 1'b0);
    tick();
    checks++; if (grant1 !== 4'b0001) begin errors++; $display("FAIL tie_low_index got %b want 0001", grant1); end
    rpl1[0] = pk(1'b0, 4'd0, 1'b1);
    tick();
    rpl1[0] = '0;
    tick();
    checks++; if (grant1 !== 4'b0010) begin errors++; $display("FAIL tie_second got %b want 0010", grant1); end
    rpl1[1] = pk(1'b0, 4'd0, 1'b1);
    tick();
    rpl1[1] = '0;
    tick();
  endtask

  task automatic test_multi_slot();
    rpl2[0] = pk(1'b1, 4'd6, 1'b0);
    rpl2[1] = pk(1'b1, 4'd4, 1'b0);
    rpl2[2] = pk(1'b1, 4'd5, 1'b0);
    rpl2[3] = pk(1'b1, 4'd7, 1'b0);
    tick();
    checks++; if (grant2 !== 4'b0010 || busy2 !== 2'b01 || owner2[0] !== 2'd1) begin errors++; $display("FAIL multi_first got %b busy %b owner0 %0d want 0010 01 1", grant2, busy2, owner2[0]); end
    tick();
    checks++; if (grant2 !== 4'b0110 || busy2 !== 2'b11 || owner2[1] !== 2'd2) begin errors++; $display("FAIL multi_second got %b busy %b owner1 %0d want 0110 11 2", grant2, busy2, owner2[1]); end
    tick();
    checks++; if (grant2 !== 4'b0110) begin errors++; $display("FAIL multi_full_wait got %b want 0110", grant2); end
    rpl2[1] = '0;
    tick();
    rpl2[1] = pk(1'b0, 4'd0, 1'b1);
    tick();
    checks++; if (grant2 !== 4'b0100 || busy2 !== 2'b10) begin errors++; $display("FAIL multi_release got %b busy %b want 0100 10", grant2, busy2); end
    rpl2[1] = '0;
    tick();
    checks++; if (grant2 !== 4'b0101 || busy2 !== 2'b11 || owner2[0] !== 2'd0) begin errors++; $display("FAIL multi_third got %b busy %b owner0 %0d want 0101 11 0", grant2, busy2, owner2[0]); end
    rpl2[0] = '0;
    rpl2[2] = '0;
    tick();
    rpl2[0] = pk(1'b0, 4'd0, 1'b1);
    rpl2[2] = pk(1'b0, 4'd0, 1'b1);
    tick();
    checks++; if (grant2 !== 4'b0000 || busy2 !== 2'b00 || err2 !== 1'b0) begin errors++; $display("FAIL multi_dual_release got %b busy %b err %b want 0000 00 0", grant2, busy2, err2); end
    rpl2[0] = '0;
    rpl2[2] = '0;
    tick();
    checks++; if (grant2 !== 4'b1000 || owner2[0] !== 2'd3) begin errors++; $display("FAIL multi_fourth got %b owner0 %0d want 1000 3", grant2, owner2[0]); end
  endtask

  task automatic test_protocol_err();
    rpl1[1] = pk(1'b0, 4'd0, 1'b1);
    tick();
    checks++; if (err1 !== 1'b1 || grant1 !== 4'b0000) begin errors++; $display("FAIL proto_set got err %b grant %b want 1 0000", err1, grant1); end
    rpl1[1] = '0;
    tick();
    tick();
    checks++; if (err1 !== 1'b1) begin errors++; $display("FAIL proto_sticky got %b want 1", err1); end
  endtask

  task automatic test_reset_mid_hold();
    rpl1[0] = pk(1'b1, 4'd4, 1'b0);
    tick();
    checks++; if (grant1 !== 4'b0001) begin errors++; $display("FAIL rst_hold_pre got %b want 0001", grant1); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (grant1 !== 4'b0000 || busy1 !== 1'b0 || err1 !== 1'b0) begin errors++; $display("FAIL rst_async got grant %b busy %b err %b want 0000 0 0", grant1, busy1, err1); end
    rst_n = 1'b1;
    tick();
    checks++; if (grant1 !== 4'b0001 || owner1[0] !== 2'd0) begin errors++; $display("FAIL rst_regrant got %b owner %0d want 0001 0", grant1, owner1[0]); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_age_order();
    test_wrap_and_tie();
    test_multi_slot();
    test_protocol_err();
    test_reset_mid_hold();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
